alu_seq_core: RTL

- Parametrised, registered successor to the combinational 16-bit ALU.
- Keeps the same 5-bit `sel_alu` opcode set from `opcode.vh` (arith, logic, compare, shift).
- Adds `WIDTH` generalisation, valid/ready handshakes, registered result and flags, and iterative multi-cycle MUL/DIV.
- Sits between the register-file read stage and writeback; it can apply backpressure.

---
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_seq_core.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode request channel and result/flags response
// channel of the sequential ALU, each with its own valid/ready pair.
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       sel_alu;
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic             carryin;
   logic             borrowin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic [8:0]       flags;
   logic             illegal_op;

   // Producer of operations and consumer of results (e.g. pipeline control).
   modport master (
      output in_valid, sel_alu, in0, in1, carryin, borrowin, out_ready,
      input  in_ready, out_valid, result, result_hi, flags, illegal_op
   );

   // The ALU core itself.
   modport slave (
      input  in_valid, sel_alu, in0, in1, carryin, borrowin, out_ready,
      output in_ready, out_valid, result, result_hi, flags, illegal_op
   );
endinterface

// File: rtl/alu_seq_core.sv
// alu_seq_core: registered ALU with valid/ready handshakes. Single-cycle ops
// (add/sub, logic, compare, shift/rotate) return one cycle after accept;
// MUL (shift-add) and DIV (restoring) iterate WIDTH cycles.
// flags = {ET, LT, GT, divbyzero, overflow, borrow, carry, negative, zero}.
// Build option: define ALU_SATURATE_EN to clamp ADD/SUB on signed overflow
// instead of wrapping.
module alu_seq_core #(
   parameter int WIDTH = 16
) (
   input logic      clk,
   input logic      rst_n,
   alu_seq_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   // Opcode map
   localparam logic [4:0] OP_ADD     = 5'b00000;
   localparam logic [4:0] OP_SUB     = 5'b00001;
   localparam logic [4:0] OP_AND     = 5'b00010;
   localparam logic [4:0] OP_OR      = 5'b00011;
   localparam logic [4:0] OP_XOR     = 5'b00100;
   localparam logic [4:0] OP_NOT     = 5'b00101;
   localparam logic [4:0] OP_CMP_GTU = 5'b01000;
   localparam logic [4:0] OP_CMP_GTS = 5'b01001;
   localparam logic [4:0] OP_CMP_LTU = 5'b01010;
   localparam logic [4:0] OP_CMP_LTS = 5'b01011;
   localparam logic [4:0] OP_CMP_ETU = 5'b01100;
   localparam logic [4:0] OP_CMP_ETS = 5'b01101;
   localparam logic [4:0] OP_SLL     = 5'b10000;
   localparam logic [4:0] OP_SRL     = 5'b10001;
   localparam logic [4:0] OP_SRA     = 5'b10010;
   localparam logic [4:0] OP_ROL     = 5'b10011;
   localparam logic [4:0] OP_ROR     = 5'b10100;
   localparam logic [4:0] OP_MUL     = 5'b11000;
   localparam logic [4:0] OP_DIV     = 5'b11001;

`ifdef ALU_SATURATE_EN
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ITER = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result_hi_q;
   logic [8:0]       flags_q;
   logic             illegal_q;

   // Iteration state shared by MUL and DIV
   logic [WIDTH-1:0] acc_hi_q;   // partial product high half / partial remainder
   logic [WIDTH-1:0] acc_lo_q;   // multiplier / dividend shifting into quotient
   logic [WIDTH-1:0] opnd_q;     // multiplicand / divisor
   logic             is_div_q;
   logic [SHW-1:0]   cnt_q;

   // Single-cycle datapath terms on the live inputs
   logic [WIDTH:0]   add_s;
   logic [WIDTH:0]   sub_s;
   logic             add_ovf_s;
   logic             sub_ovf_s;
   logic             cmp_gt_s;
   logic             cmp_lt_s;
   logic             cmp_et_s;
   logic [SHW-1:0]   amt_s;
   logic [SHW:0]     inv_amt_s;
   logic             is_iter_s;

   logic [WIDTH-1:0] alu_res_s;
   logic [WIDTH-1:0] alu_hi_s;
   logic [8:0]       alu_flags_s;
   logic             alu_ill_s;
   logic             gt_s, lt_s, et_s, dz_s, ov_s, bw_s, cy_s;

   // Iteration step terms
   logic [WIDTH:0]   mul_sum_s;
   logic [WIDTH:0]   div_tmp_s;
   logic [WIDTH:0]   div_sub_s;
   logic             div_ge_s;
   logic [WIDTH-1:0] step_hi_s;
   logic [WIDTH-1:0] step_lo_s;

   assign add_s     = {1'b0, bus.in0} + {1'b0, bus.in1} + {{WIDTH{1'b0}}, bus.carryin};
   assign sub_s     = {1'b0, bus.in0} - {1'b0, bus.in1} - {{WIDTH{1'b0}}, bus.borrowin};
   assign add_ovf_s = (bus.in0[WIDTH-1] == bus.in1[WIDTH-1]) && (add_s[WIDTH-1] != bus.in0[WIDTH-1]);
   assign sub_ovf_s = (bus.in0[WIDTH-1] != bus.in1[WIDTH-1]) && (sub_s[WIDTH-1] != bus.in0[WIDTH-1]);
   assign cmp_gt_s  = bus.sel_alu[0] ? ($signed(bus.in0) > $signed(bus.in1)) : (bus.in0 > bus.in1);
   assign cmp_lt_s  = bus.sel_alu[0] ? ($signed(bus.in0) < $signed(bus.in1)) : (bus.in0 < bus.in1);
   assign cmp_et_s  = (bus.in0 == bus.in1);
   assign amt_s     = bus.in1[SHW-1:0];
   // Shift by WIDTH yields zero, so a rotate by 0 degenerates to in0 | 0.
   assign inv_amt_s = (SHW+1)'(WIDTH) - {1'b0, amt_s};
   assign is_iter_s = (bus.sel_alu == OP_MUL) ||
                      ((bus.sel_alu == OP_DIV) && (bus.in1 != {WIDTH{1'b0}}));

   // Shift-add multiply step: add multiplicand when LSB set, shift right.
   assign mul_sum_s = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
   // Restoring divide step: shift next dividend bit in, subtract if it fits.
   assign div_tmp_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign div_sub_s = div_tmp_s - {1'b0, opnd_q};
   assign div_ge_s  = ~div_sub_s[WIDTH];

   // Select the next iteration value for whichever operation is running.
   always_comb begin
      step_hi_s = {WIDTH{1'b0}};
      step_lo_s = {WIDTH{1'b0}};
      if (is_div_q) begin
         step_hi_s = div_ge_s ? div_sub_s[WIDTH-1:0] : div_tmp_s[WIDTH-1:0];
         step_lo_s = {acc_lo_q[WIDTH-2:0], div_ge_s};
      end else begin
         step_hi_s = mul_sum_s[WIDTH:1];
         step_lo_s = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
      end
   end

   // Decode the opcode into the single-cycle result, high word and flags.
   always_comb begin
      alu_res_s = {WIDTH{1'b0}};
      alu_hi_s  = {WIDTH{1'b0}};
      alu_ill_s = 1'b0;
      gt_s = 1'b0; lt_s = 1'b0; et_s = 1'b0; dz_s = 1'b0;
      ov_s = 1'b0; bw_s = 1'b0; cy_s = 1'b0;
      case (bus.sel_alu)
         OP_ADD: begin
            cy_s = add_s[WIDTH];
            ov_s = add_ovf_s;
`ifdef ALU_SATURATE_EN
            if (add_ovf_s) alu_res_s = bus.in0[WIDTH-1] ? SMIN : SMAX;
            else           alu_res_s = add_s[WIDTH-1:0];
`else
            alu_res_s = add_s[WIDTH-1:0];
`endif
         end
         OP_SUB: begin
            bw_s = sub_s[WIDTH];
            ov_s = sub_ovf_s;
`ifdef ALU_SATURATE_EN
            if (sub_ovf_s) alu_res_s = bus.in0[WIDTH-1] ? SMIN : SMAX;
            else           alu_res_s = sub_s[WIDTH-1:0];
`else
            alu_res_s = sub_s[WIDTH-1:0];
`endif
         end
         OP_AND: alu_res_s = bus.in0 & bus.in1;
         OP_OR:  alu_res_s = bus.in0 | bus.in1;
         OP_XOR: alu_res_s = bus.in0 ^ bus.in1;
         OP_NOT: alu_res_s = ~bus.in0;
         OP_CMP_GTU, OP_CMP_GTS, OP_CMP_LTU, OP_CMP_LTS, OP_CMP_ETU, OP_CMP_ETS: begin
            gt_s = cmp_gt_s;
            lt_s = cmp_lt_s;
            et_s = cmp_et_s;
            case (bus.sel_alu[2:1])
               2'b00:   alu_res_s = {{(WIDTH-1){1'b0}}, cmp_gt_s};
               2'b01:   alu_res_s = {{(WIDTH-1){1'b0}}, cmp_lt_s};
               2'b10:   alu_res_s = {{(WIDTH-1){1'b0}}, cmp_et_s};
               default: alu_res_s = {WIDTH{1'b0}};
            endcase
         end
         OP_SLL: alu_res_s = bus.in0 << amt_s;
         OP_SRL: alu_res_s = bus.in0 >> amt_s;
         OP_SRA: alu_res_s = $signed(bus.in0) >>> amt_s;
         OP_ROL: alu_res_s = (bus.in0 << amt_s) | (bus.in0 >> inv_amt_s);
         OP_ROR: alu_res_s = (bus.in0 >> amt_s) | (bus.in0 << inv_amt_s);
         OP_MUL: alu_res_s = {WIDTH{1'b0}};
         OP_DIV: begin
            // Only the divide-by-zero shortcut resolves here.
            if (bus.in1 == {WIDTH{1'b0}}) begin
               alu_res_s = {WIDTH{1'b1}};
               alu_hi_s  = bus.in0;
               dz_s      = 1'b1;
            end else begin
               alu_hi_s  = {WIDTH{1'b0}};
            end
         end
         default: alu_ill_s = 1'b1;
      endcase
      alu_flags_s = {et_s, lt_s, gt_s, dz_s, ov_s, bw_s, cy_s,
                     alu_res_s[WIDTH-1], (alu_res_s == {WIDTH{1'b0}})};
   end

   // Control FSM with registered handshake, result and flag outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= {WIDTH{1'b0}};
         result_hi_q <= {WIDTH{1'b0}};
         flags_q     <= 9'b0;
         illegal_q   <= 1'b0;
         acc_hi_q    <= {WIDTH{1'b0}};
         acc_lo_q    <= {WIDTH{1'b0}};
         opnd_q      <= {WIDTH{1'b0}};
         is_div_q    <= 1'b0;
         cnt_q       <= {SHW{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  in_ready_q <= 1'b0;
                  if (is_iter_s) begin
                     acc_hi_q <= {WIDTH{1'b0}};
                     acc_lo_q <= bus.in0;
                     opnd_q   <= bus.in1;
                     is_div_q <= (bus.sel_alu == OP_DIV);
                     cnt_q    <= {SHW{1'b0}};
                     state_q  <= ITER;
                  end else begin
                     result_q    <= alu_res_s;
                     result_hi_q <= alu_hi_s;
                     flags_q     <= alu_flags_s;
                     illegal_q   <= alu_ill_s;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            ITER: begin
               acc_hi_q <= step_hi_s;
               acc_lo_q <= step_lo_s;
               cnt_q    <= cnt_q + SHW'(1);
               if (cnt_q == SHW'(WIDTH-1)) begin
                  result_q    <= step_lo_s;
                  result_hi_q <= step_hi_s;
                  flags_q     <= {7'b0, step_lo_s[WIDTH-1], (step_lo_s == {WIDTH{1'b0}})};
                  illegal_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  state_q     <= ITER;
               end
            end
            DONE: begin
               if (out_valid_q && bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  state_q     <= DONE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.result     = result_q;
   assign bus.result_hi  = result_hi_q;
   assign bus.flags      = flags_q;
   assign bus.illegal_op = illegal_q;

endmodule
